// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 key decoder: prefix tracking, key mapping, held bitmap and event FIFO.
module ps2_key_decoder #(
  parameter int unsigned DEPTH_LOG2      = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 50000,
  parameter int unsigned SUPPRESS_REPEAT = 1
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       scan_code_ready,
  input  logic [7:0] scan_code,
  input  logic       parity_flag,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [3:0] event_code,
  output logic       event_release,
  output logic [7:0] key_state,
  output logic       overflow,
  output logic [7:0] parity_err_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic SUPP = (SUPPRESS_REPEAT != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_ready_d;
  logic [TMO_W-1:0]      r_tmo;
  logic [7:0]            r_key_state;
  logic                  r_overflow;
  logic [7:0]            r_perr;
  logic [4:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic       w_accept;
  logic       w_make;
  logic       w_release;
  logic [3:0] w_key;
  logic [2:0] w_idx;
  logic       w_held;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_wr;

  // Set-2 byte to game key enum; 0 means unmapped.
  function automatic logic [3:0] f_map(input logic [7:0] b);
    case (b)
      8'h75, 8'h1D: f_map = 4'd1;
      8'h72, 8'h1B: f_map = 4'd2;
      8'h6B, 8'h1C: f_map = 4'd3;
      8'h74, 8'h23: f_map = 4'd4;
      8'h2D:        f_map = 4'd5;
      8'h3C:        f_map = 4'd6;
      8'h76:        f_map = 4'd7;
      8'h5A:        f_map = 4'd8;
      default:      f_map = 4'd0;
    endcase
  endfunction

  assign w_accept = scan_code_ready && !r_ready_d;
  assign w_key    = f_map(scan_code);
  assign w_idx    = 3'(w_key - 4'd1);
  assign w_held   = r_key_state[w_idx];
  assign w_push   = (w_key != 4'd0) &&
                    ((w_make && !(w_held && SUPP)) || (w_release && w_held));
  assign w_pop    = (r_count != '0) && event_ready;
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_wr     = w_push && (!w_full || w_pop);

  // Prefix state register.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and make/release decode for the accepted byte.
  always_comb begin
    w_state_next = r_state;
    w_make       = 1'b0;
    w_release    = 1'b0;
    if (w_accept) begin
      if (!parity_flag) begin
        w_state_next = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (scan_code == 8'hE0)      w_state_next = S_EXT;
            else if (scan_code == 8'hF0) w_state_next = S_BRK;
            else begin
              w_make       = 1'b1;
              w_state_next = S_IDLE;
            end
          end
          S_EXT: begin
            if (scan_code == 8'hF0)      w_state_next = S_EXT_BRK;
            else if (scan_code == 8'hE0) w_state_next = S_EXT;
            else begin
              w_make       = 1'b1;
              w_state_next = S_IDLE;
            end
          end
          default: begin
            w_state_next = S_IDLE;
            if (scan_code != 8'hE0 && scan_code != 8'hF0) w_release = 1'b1;
          end
        endcase
      end
    end else if (r_state != S_IDLE && r_tmo == TMO_LAST) begin
      w_state_next = S_IDLE;
    end
  end

  // Edge detect, prefix timeout, held bitmap and parity error count.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_ready_d   <= 1'b0;
      r_tmo       <= '0;
      r_key_state <= '0;
      r_perr      <= '0;
    end else begin
      r_ready_d <= scan_code_ready;
      if (w_accept || r_state == S_IDLE || r_tmo == TMO_LAST) r_tmo <= '0;
      else                                                    r_tmo <= r_tmo + TMO_W'(1);
      if (w_push) r_key_state[w_idx] <= w_make;
      if (w_accept && !parity_flag && r_perr != 8'hFF) r_perr <= r_perr + 8'd1;
    end
  end

  // Event FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= {w_release, w_key};
        r_wr_ptr        <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign event_valid      = (r_count != '0);
  assign event_code       = r_mem[r_rd_ptr][3:0];
  assign event_release    = r_mem[r_rd_ptr][4];
  assign key_state        = r_key_state;
  assign overflow         = r_overflow;
  assign parity_err_count = r_perr;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: vector table plus scoreboarded event stream.
module tb_ps2_key_decoder;

  localparam int unsigned TMO = 40;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       scan_code_ready;
  logic [7:0] scan_code;
  logic       parity_flag;
  logic       event_valid;
  logic       event_ready;
  logic [3:0] event_code;
  logic       event_release;
  logic [7:0] key_state;
  logic       overflow;
  logic [7:0] parity_err_count;

  ps2_key_decoder #(
    .DEPTH_LOG2(2),
    .TIMEOUT_CYCLES(TMO),
    .SUPPRESS_REPEAT(1)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .scan_code_ready(scan_code_ready),
    .scan_code(scan_code),
    .parity_flag(parity_flag),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_code(event_code),
    .event_release(event_release),
    .key_state(key_state),
    .overflow(overflow),
    .parity_err_count(parity_err_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [7:0] code;
    logic       par;
    logic       ev;
    logic       rel;
    logic [3:0] k;
    logic [7:0] keys;
  } vec_t;

  localparam int NVEC = 33;
  vec_t       tbl [NVEC];
  logic [4:0] exp_q [$];
  logic [4:0] m_exp;
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic vec_t v(input logic [7:0] c, input logic p, input logic e,
                             input logic r, input logic [3:0] k, input logic [7:0] ks);
    v = '{code: c, par: p, ev: e, rel: r, k: k, keys: ks};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every handshake pops and compares the oldest expected event.
  always @(negedge sys_clk) begin
    #1;
    if (!reset && event_valid && event_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got rel=%0d code=%0d, required none",
                 event_release, event_code);
      end else begin
        m_exp = exp_q.pop_front();
        check("event", 32'({event_release, event_code}), 32'(m_exp));
      end
    end
  end

  task automatic send_byte(input logic [7:0] c, input logic p, input int hold);
    @(negedge sys_clk);
    scan_code       = c;
    parity_flag     = p;
    scan_code_ready = 1'b1;
    repeat (hold) @(negedge sys_clk);
    scan_code_ready = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic make_key(input logic [7:0] c, input logic [3:0] k, input logic expect_ev);
    if (expect_ev) exp_q.push_back({1'b0, k});
    send_byte(c, 1'b1, 1);
  endtask

  task automatic release_key(input logic [7:0] c, input logic [3:0] k);
    exp_q.push_back({1'b1, k});
    send_byte(8'hF0, 1'b1, 1);
    send_byte(c, 1'b1, 1);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge sys_clk);
    end
    repeat (2) @(negedge sys_clk);
    check({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({nm, "_valid_low"}, 32'(event_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_valid"}, 32'(event_valid), 32'd0);
    check({nm, "_code"}, 32'(event_code), 32'd0);
    check({nm, "_rel"}, 32'(event_release), 32'd0);
    check({nm, "_keys"}, 32'(key_state), 32'd0);
    check({nm, "_ovf"}, 32'(overflow), 32'd0);
    check({nm, "_perr"}, 32'(parity_err_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = v(8'h75, 1'b1, 1'b1, 1'b0, 4'd1, 8'h01);
    tbl[1]  = v(8'hF0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h01);
    tbl[2]  = v(8'h75, 1'b1, 1'b1, 1'b1, 4'd1, 8'h00);
    tbl[3]  = v(8'hE0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tbl[4]  = v(8'h74, 1'b1, 1'b1, 1'b0, 4'd4, 8'h08);
    tbl[5]  = v(8'hE0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h08);
    tbl[6]  = v(8'hF0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h08);
    tbl[7]  = v(8'h74, 1'b1, 1'b1, 1'b1, 4'd4, 8'h00);
    tbl[8]  = v(8'h1D, 1'b1, 1'b1, 1'b0, 4'd1, 8'h01);
    tbl[9]  = v(8'h1D, 1'b1, 1'b0, 1'b0, 4'd0, 8'h01);
    tbl[10] = v(8'h1D, 1'b1, 1'b0, 1'b0, 4'd0, 8'h01);
    tbl[11] = v(8'hF0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h01);
    tbl[12] = v(8'h1D, 1'b1, 1'b1, 1'b1, 4'd1, 8'h00);
    tbl[13] = v(8'h75, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    tbl[14] = v(8'hF0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tbl[15] = v(8'h6B, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tbl[16] = v(8'hAA, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tbl[17] = v(8'hFA, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tbl[18] = v(8'hE0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tbl[19] = v(8'h5A, 1'b1, 1'b1, 1'b0, 4'd8, 8'h80);
    tbl[20] = v(8'hF0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h80);
    tbl[21] = v(8'h5A, 1'b1, 1'b1, 1'b1, 4'd8, 8'h00);
    tbl[22] = v(8'hF0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tbl[23] = v(8'hE0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tbl[24] = v(8'h75, 1'b1, 1'b1, 1'b0, 4'd1, 8'h01);
    tbl[25] = v(8'hF0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h01);
    tbl[26] = v(8'h75, 1'b1, 1'b1, 1'b1, 4'd1, 8'h00);
    tbl[27] = v(8'hE0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tbl[28] = v(8'hE0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    tbl[29] = v(8'h72, 1'b1, 1'b1, 1'b0, 4'd2, 8'h02);
    tbl[30] = v(8'hE0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h02);
    tbl[31] = v(8'hF0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h02);
    tbl[32] = v(8'h72, 1'b1, 1'b1, 1'b1, 4'd2, 8'h00);

    reset           = 1'b1;
    scan_code_ready = 1'b0;
    scan_code       = 8'h00;
    parity_flag     = 1'b1;
    event_ready     = 1'b1;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    check_all_zero("reset");

    // Vector table with the consumer always ready.
    for (int i = 0; i < NVEC; i++) begin
      if (tbl[i].ev) exp_q.push_back({tbl[i].rel, tbl[i].k});
      send_byte(tbl[i].code, tbl[i].par, 1);
      check($sformatf("vec%0d_keys", i), 32'(key_state), 32'(tbl[i].keys));
    end
    drain("table");
    check("perr_count", 32'(parity_err_count), 32'd1);

    // Event appears exactly one cycle after the accepting edge.
    exp_q.push_back({1'b0, 4'd7});
    @(negedge sys_clk);
    scan_code = 8'h76; parity_flag = 1'b1; scan_code_ready = 1'b1;
    #1 check("lat_before_accept", 32'(event_valid), 32'd0);
    @(negedge sys_clk);
    #1 check("lat_after_accept", 32'(event_valid), 32'd1);
    scan_code_ready = 1'b0;
    @(negedge sys_clk);
    release_key(8'h76, 4'd7);
    drain("latency");

    // A level held for several cycles is a single accept.
    exp_q.push_back({1'b0, 4'd6});
    send_byte(8'h3C, 1'b1, 4);
    release_key(8'h3C, 4'd6);
    drain("level");

    // Prefix timeout: E0 abandoned, following F0 is a plain break.
    make_key(8'h75, 4'd1, 1'b1);
    send_byte(8'hE0, 1'b1, 1);
    repeat (TMO + 10) @(negedge sys_clk);
    release_key(8'h75, 4'd1);
    drain("tmo_ext");
    check("tmo_ext_keys", 32'(key_state), 32'd0);
    // Break abandoned by timeout turns the next byte into a (suppressed) make.
    make_key(8'h75, 4'd1, 1'b1);
    send_byte(8'hF0, 1'b1, 1);
    repeat (TMO + 10) @(negedge sys_clk);
    send_byte(8'h75, 1'b1, 1);
    drain("tmo_brk");
    check("tmo_brk_keys", 32'(key_state), 32'd1);
    // A break that waits less than the timeout still completes.
    send_byte(8'hF0, 1'b1, 1);
    repeat (TMO - 10) @(negedge sys_clk);
    exp_q.push_back({1'b1, 4'd1});
    send_byte(8'h75, 1'b1, 1);
    drain("tmo_short");
    check("tmo_short_keys", 32'(key_state), 32'd0);

    // Full FIFO with simultaneous push and pop: no loss, no overflow.
    event_ready = 1'b0;
    make_key(8'h75, 4'd1, 1'b1);
    make_key(8'h72, 4'd2, 1'b1);
    make_key(8'h6B, 4'd3, 1'b1);
    make_key(8'h74, 4'd4, 1'b1);
    check("full_keys", 32'(key_state), 32'h0F);
    exp_q.push_back({1'b0, 4'd5});
    @(negedge sys_clk);
    scan_code = 8'h2D; parity_flag = 1'b1; scan_code_ready = 1'b1; event_ready = 1'b1;
    @(negedge sys_clk);
    scan_code_ready = 1'b0;
    drain("pushpop");
    check("pushpop_ovf", 32'(overflow), 32'd0);
    check("pushpop_keys", 32'(key_state), 32'h1F);
    release_key(8'h75, 4'd1);
    release_key(8'h72, 4'd2);
    release_key(8'h6B, 4'd3);
    release_key(8'h74, 4'd4);
    release_key(8'h2D, 4'd5);
    drain("pushpop_rel");

    // Overflow: fifth make dropped, key still recorded, head order preserved.
    event_ready = 1'b0;
    make_key(8'h75, 4'd1, 1'b1);
    make_key(8'h72, 4'd2, 1'b1);
    make_key(8'h6B, 4'd3, 1'b1);
    make_key(8'h74, 4'd4, 1'b1);
    make_key(8'h2D, 4'd5, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_keys", 32'(key_state), 32'h1F);
    check("ovf_valid", 32'(event_valid), 32'd1);
    check("ovf_head", 32'({event_release, event_code}), 32'h01);
    event_ready = 1'b1;
    drain("ovf");
    release_key(8'h75, 4'd1);
    release_key(8'h72, 4'd2);
    release_key(8'h6B, 4'd3);
    release_key(8'h74, 4'd4);
    release_key(8'h2D, 4'd5);
    drain("ovf_rel");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset mid-break with queued events.
    event_ready = 1'b0;
    make_key(8'h75, 4'd1, 1'b0);
    make_key(8'h72, 4'd2, 1'b0);
    make_key(8'h6B, 4'd3, 1'b0);
    send_byte(8'hE0, 1'b1, 1);
    send_byte(8'hF0, 1'b1, 1);
    check("prerst_keys", 32'(key_state), 32'h07);
    check("prerst_valid", 32'(event_valid), 32'd1);
    @(negedge sys_clk);
    #2 reset = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge sys_clk);
    reset       = 1'b0;
    event_ready = 1'b1;
    make_key(8'h5A, 4'd8, 1'b1);
    drain("post_rst");
    check("post_rst_keys", 32'(key_state), 32'h80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Consumes the byte stream from the PS/2 receive interface: scan_code, scan_code_ready and the parity flag.
- Tracks F0 (break) and E0 (extended) prefixes and maps Set-2 codes onto the game's key enumeration.
- Keeps a held-key bitmap and queues make/release events in a small FIFO with a valid/ready handshake toward the game controller.

Parameters:
- DEPTH_LOG2, 2, log2 of event FIFO depth (default 4 entries)
- TIMEOUT_CYCLES, 50000, cycles a prefix state may wait for its next byte before aborting (1 ms at 50 MHz)
- SUPPRESS_REPEAT, 1, 1 = drop typematic repeat makes of a key already held

Ports:
- sys_clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- scan_code_ready  in  1  byte-available strobe/level; only its rising edge is used
- scan_code  in  8  received byte, stable while scan_code_ready is high
- parity_flag  in  1  XOR of data+parity bits; 1 = valid odd-parity frame
- event_valid  out  1  FIFO head holds an event
- event_ready  in  1  consumer accepts head when event_valid && event_ready
- event_code  out  4  key enum at FIFO head
- event_release  out  1  1 = release event, 0 = make
- key_state  out  8  held bitmap; bit k-1 corresponds to enum k
- overflow  out  1  sticky; an event was dropped because the FIFO was full
- parity_err_count  out  8  saturating count of rejected bytes

Behaviour:
- Reset (asynchronous, active-high) clears everything immediately, including mid-sequence:
  - all outputs 0; FIFO empty; FSM in IDLE; timeout counter 0; ready_d 0.
- Byte accept: ready_d registers scan_code_ready; a byte is accepted in cycle N when scan_code_ready && !ready_d. Level or pulse input is therefore handled identically.
- Parity check:
  - parity_flag=0 on accept: byte discarded, FSM -> IDLE, parity_err_count += 1 (saturates at 255).
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: E0 -> EXT; F0 -> BRK; else decode as make -> IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay; else decode as make -> IDLE.
  - BRK, EXT_BRK: any byte except E0/F0 is decoded as release -> IDLE. E0/F0 in these states -> IDLE, byte dropped.
  - In any non-IDLE state, the timeout counter increments each cycle with no accept. On reaching TIMEOUT_CYCLES-1: FSM -> IDLE, nothing emitted. The counter clears on every accept and in IDLE.
- Key map (E0 prefix optional for all entries):
  - 1 up: 75, 1D
  - 2 down: 72, 1B
  - 3 left: 6B, 1C
  - 4 right: 74, 23
  - 5 restart: 2D
  - 6 undo: 3C
  - 7 esc: 76
  - 8 enter: 5A
- Unmapped bytes (including AA, FA, FE, 00, FF, E1) emit nothing and return the FSM to IDLE.
- Make for enum k:
  - if key_state[k-1]=1 and SUPPRESS_REPEAT=1: drop;
  - else set key_state[k-1] and push {0,k}.
- Release for enum k:
  - if key_state[k-1]=0: drop (no spurious releases);
  - else clear key_state[k-1] and push {1,k}.
- Latency: key_state and the FIFO write update at the end of the accept cycle N. event_valid is high in N+1 when the FIFO was empty.
- FIFO:
  - Synchronous, 5-bit entries {release, code}, head presented combinationally from storage.
  - Pop on event_valid && event_ready.
  - Push when full with no pop: event dropped, overflow set (sticky until reset).
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Pop when empty: ignored.
  - Pointers wrap modulo 2^DEPTH_LOG2.
- key_state still updates when the push is dropped.

Test Plan:
- Bytes 75, then F0 75, event_ready=1 -> events {0,1} then {1,1}; key_state 01 then 00; each event_valid one cycle after its accept.
- E0 74, E0 F0 74 -> {0,4}, {1,4}. Bytes 1D 1D 1D with SUPPRESS_REPEAT=1 -> a single {0,1}.
- event_ready=0; makes for enums 1,2,3,4,5 -> FIFO holds 4 events, fifth dropped, overflow=1, key_state=1F. Then event_ready=1 -> codes 1,2,3,4 drain in order, event_valid falls.
- E0 followed by silence of TIMEOUT_CYCLES -> FSM IDLE; next byte F0 is treated as a fresh break prefix (state BRK, not EXT_BRK).
- Byte 75 with parity_flag=0 -> no event, parity_err_count=1. Byte F0 6B with 6B not held -> no event. Bytes AA, FA -> no event.
- Assert reset while in EXT_BRK with 3 queued events and key_state=07 -> all outputs 0 immediately. A following 5A after reset release -> {0,8}.
